// File: rtl/hub_port_tx.sv
// Hub egress-port transmitter: pops one byte at a time from the hub FIFO and
// sends it as an async frame (start, 8 data LSB first, optional even parity, stop).
module hub_port_tx #(
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter int unsigned PARITY_EN    = 0,
  parameter int unsigned COUNT_W      = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               fifo_empty,
  input  logic [7:0]         fifo_dout,
  output logic               fifo_r,
  output logic               tx,
  output logic               busy,
  output logic               tx_done,
  output logic [COUNT_W-1:0] frame_count
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, READ, LOAD, START, DATA, PARITY, STOP} state_t;

  state_t           state, state_d;
  logic [CNT_W-1:0] clk_cnt, clk_cnt_d;
  logic [2:0]       bit_cnt, bit_cnt_d;
  logic [7:0]       shift, shift_d;
  logic             par, par_d;
  logic             tx_d, busy_d, fifo_r_d, tx_done_d;
  logic             bit_end;

  // Next-state logic; outputs are derived from the next state so they register
  // in step with the state they describe.
  always_comb begin
    state_d   = state;
    clk_cnt_d = clk_cnt;
    bit_cnt_d = bit_cnt;
    shift_d   = shift;
    par_d     = par;
    bit_end   = (clk_cnt == CNT_LAST);

    case (state)
      IDLE: begin
        if (!fifo_empty) state_d = READ;
      end
      READ: begin
        state_d = LOAD;
      end
      LOAD: begin
        shift_d   = fifo_dout;
        par_d     = ^fifo_dout;
        clk_cnt_d = '0;
        state_d   = START;
      end
      START: begin
        if (bit_end) begin
          clk_cnt_d = '0;
          bit_cnt_d = '0;
          state_d   = DATA;
        end else begin
          clk_cnt_d = clk_cnt + CNT_W'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          clk_cnt_d = '0;
          shift_d   = {1'b0, shift[7:1]};
          if (bit_cnt == 3'd7) begin
            bit_cnt_d = '0;
            state_d   = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            bit_cnt_d = bit_cnt + 3'd1;
          end
        end else begin
          clk_cnt_d = clk_cnt + CNT_W'(1);
        end
      end
      PARITY: begin
        if (bit_end) begin
          clk_cnt_d = '0;
          state_d   = STOP;
        end else begin
          clk_cnt_d = clk_cnt + CNT_W'(1);
        end
      end
      STOP: begin
        if (bit_end) begin
          clk_cnt_d = '0;
          state_d   = IDLE;
        end else begin
          clk_cnt_d = clk_cnt + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    tx_d = 1'b1;
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      PARITY:  tx_d = par_d;
      default: tx_d = 1'b1;
    endcase
    busy_d    = (state_d != IDLE);
    fifo_r_d  = (state_d == READ);
    tx_done_d = (state_d == STOP) && (clk_cnt_d == CNT_LAST);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      clk_cnt     <= '0;
      bit_cnt     <= '0;
      shift       <= '0;
      par         <= 1'b0;
      tx          <= 1'b1;
      busy        <= 1'b0;
      fifo_r      <= 1'b0;
      tx_done     <= 1'b0;
      frame_count <= '0;
    end else begin
      state       <= state_d;
      clk_cnt     <= clk_cnt_d;
      bit_cnt     <= bit_cnt_d;
      shift       <= shift_d;
      par         <= par_d;
      tx          <= tx_d;
      busy        <= busy_d;
      fifo_r      <= fifo_r_d;
      tx_done     <= tx_done_d;
      frame_count <= frame_count + COUNT_W'(tx_done_d);
    end
  end

endmodule
